// File: rtl/croc_seq_pkg.sv
// Shared types and default timing constants for the croc run sequencer.
package croc_seq_pkg;

    // Campaign controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        BOOT  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    // Default phase lengths, in SoC clock cycles.
    localparam int unsigned DefRstHoldCycles  = 16;
    localparam int unsigned DefBootWaitCycles = 8;
    localparam int unsigned DefTimeoutCycles  = 1048576;

endpackage

// File: rtl/croc_seq_timer.sv
// Loadable up-counter with terminal-value compare, shared by the RESET,
// BOOT and RUN phases. Load has priority over enable.
module croc_seq_timer #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    input  logic [Width-1:0] term_i,
    output logic [Width-1:0] cnt_o,
    output logic             hit_o
);

    logic [Width-1:0] cnt_q;

    // Count register: clear on reset, load a start value, or step by one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;
    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/croc_run_sequencer.sv
// Autonomous campaign controller for croc_soc: repeatedly resets, boots and
// runs the SoC, then records pass/fail/timeout statistics for VIO probes.
// Handshake: start_i is a level sampled only in IDLE (accepted when abort_i
// is low); abort_i is sampled every cycle and wins over everything outside
// IDLE; status_i/result_i are sampled only in RUN; done_o pulses for one
// cycle when a campaign completes normally.
module croc_run_sequencer
    import croc_seq_pkg::*;
#(
    parameter int unsigned RstHoldCycles  = DefRstHoldCycles,
    parameter int unsigned BootWaitCycles = DefBootWaitCycles,
    parameter int unsigned TimeoutCycles  = DefTimeoutCycles,
    parameter int unsigned CountWidth     = 16,
    parameter int unsigned CycleWidth     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [CountWidth-1:0] run_count_i,
    input  logic                  status_i,
    input  logic                  result_i,
    output logic                  soc_rst_no,
    output logic                  soc_fetch_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [CountWidth-1:0] pass_cnt_o,
    output logic [CountWidth-1:0] fail_cnt_o,
    output logic [CountWidth-1:0] timeout_cnt_o,
    output logic [CycleWidth-1:0] last_cycles_o,
    output logic [2:0]            dbg_state_o
);

    localparam logic [CycleWidth-1:0] RstTerm     = CycleWidth'(RstHoldCycles);
    localparam logic [CycleWidth-1:0] BootTerm    = CycleWidth'(BootWaitCycles);
    localparam logic [CycleWidth-1:0] TimeoutTerm = CycleWidth'(TimeoutCycles);
    localparam logic [CycleWidth-1:0] TimerStart  = CycleWidth'(1);

    seq_state_e            state_q;
    logic                  soc_rst_n_q;
    logic                  fetch_en_q;
    logic                  busy_q;
    logic                  done_q;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] runs_done_q;
    logic [CountWidth-1:0] pass_q;
    logic [CountWidth-1:0] fail_q;
    logic [CountWidth-1:0] timeout_q;
    logic [CycleWidth-1:0] last_cycles_q;

    logic                  tmr_load;
    logic                  tmr_en;
    logic [CycleWidth-1:0] tmr_term;
    logic [CycleWidth-1:0] tmr_cnt;
    logic                  tmr_hit;
    logic [CountWidth-1:0] runs_done_d;

    croc_seq_timer #(
        .Width(CycleWidth)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .load_val_i (TimerStart),
        .en_i       (tmr_en),
        .term_i     (tmr_term),
        .cnt_o      (tmr_cnt),
        .hit_o      (tmr_hit)
    );

    // Timer control: the counter reads 1 in the first cycle of every timed
    // phase, so it is reloaded whenever a phase ends and in all untimed states.
    always_comb begin
        tmr_load    = 1'b1;
        tmr_en      = 1'b0;
        tmr_term    = '0;
        runs_done_d = runs_done_q + 1'b1;
        case (state_q)
            RESET: begin
                tmr_term = RstTerm;
                tmr_load = tmr_hit;
                tmr_en   = ~tmr_hit;
            end
            BOOT: begin
                tmr_term = BootTerm;
                tmr_load = tmr_hit;
                tmr_en   = ~tmr_hit;
            end
            RUN: begin
                tmr_term = TimeoutTerm;
                tmr_load = status_i | tmr_hit;
                tmr_en   = ~(status_i | tmr_hit);
            end
            default: ;
        endcase
    end

    // Campaign FSM with registered SoC controls and statistics counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            soc_rst_n_q   <= 1'b0;
            fetch_en_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            count_q       <= '0;
            runs_done_q   <= '0;
            pass_q        <= '0;
            fail_q        <= '0;
            timeout_q     <= '0;
            last_cycles_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i && (state_q != IDLE)) begin
                // Abort drops straight to IDLE with the SoC held in reset;
                // statistics are kept for inspection.
                state_q     <= IDLE;
                soc_rst_n_q <= 1'b0;
                fetch_en_q  <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i && !abort_i) begin
                            count_q       <= run_count_i;
                            runs_done_q   <= '0;
                            pass_q        <= '0;
                            fail_q        <= '0;
                            timeout_q     <= '0;
                            last_cycles_q <= '0;
                            busy_q        <= 1'b1;
                            if (run_count_i == '0) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= RESET;
                            end
                        end
                    end
                    RESET: begin
                        if (tmr_hit) begin
                            state_q     <= BOOT;
                            soc_rst_n_q <= 1'b1;
                        end
                    end
                    BOOT: begin
                        if (tmr_hit) begin
                            state_q    <= RUN;
                            fetch_en_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (status_i || tmr_hit) begin
                            // Completion takes precedence over a timeout
                            // landing in the same cycle.
                            if (status_i) begin
                                last_cycles_q <= tmr_cnt;
                                if (result_i) begin
                                    pass_q <= pass_q + 1'b1;
                                end else begin
                                    fail_q <= fail_q + 1'b1;
                                end
                            end else begin
                                last_cycles_q <= TimeoutTerm;
                                fail_q        <= fail_q + 1'b1;
                                timeout_q     <= timeout_q + 1'b1;
                            end
                            runs_done_q <= runs_done_d;
                            soc_rst_n_q <= 1'b0;
                            fetch_en_q  <= 1'b0;
                            if (runs_done_d == count_q) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= RESET;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q     <= IDLE;
                        soc_rst_n_q <= 1'b0;
                        fetch_en_q  <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign soc_rst_no     = soc_rst_n_q;
    assign soc_fetch_en_o = fetch_en_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign pass_cnt_o     = pass_q;
    assign fail_cnt_o     = fail_q;
    assign timeout_cnt_o  = timeout_q;
    assign last_cycles_o  = last_cycles_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_croc_run_sequencer.sv
// Self-checking bench for croc_run_sequencer: directed campaigns plus
// randomized campaigns checked against an arithmetic campaign model.
module tb_croc_run_sequencer;
  import croc_seq_pkg::*;

  localparam int RH = 4;
  localparam int BW = 2;
  localparam int TO = 100;
  localparam int CW = 16;
  localparam int YW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [CW-1:0] run_count_i = '0;
  logic          status_i = 1'b0;
  logic          result_i = 1'b0;
  logic          soc_rst_no;
  logic          soc_fetch_en_o;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] pass_cnt_o;
  logic [CW-1:0] fail_cnt_o;
  logic [CW-1:0] timeout_cnt_o;
  logic [YW-1:0] last_cycles_o;
  logic [2:0]    dbg_state_o;

  int errors = 0;
  int checks = 0;

  // Per-run SoC behaviour: status latency in RUN cycles and result bit.
  // A latency above TO means the SoC never reports completion.
  int lat_a[8];
  bit res_a[8];

  croc_run_sequencer #(
    .RstHoldCycles (RH),
    .BootWaitCycles(BW),
    .TimeoutCycles (TO),
    .CountWidth    (CW),
    .CycleWidth    (YW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .run_count_i   (run_count_i),
    .status_i      (status_i),
    .result_i      (result_i),
    .soc_rst_no    (soc_rst_no),
    .soc_fetch_en_o(soc_fetch_en_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .pass_cnt_o    (pass_cnt_o),
    .fail_cnt_o    (fail_cnt_o),
    .timeout_cnt_o (timeout_cnt_o),
    .last_cycles_o (last_cycles_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Waits (bounded) until fetch enable is high; status stays low meanwhile.
  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (soc_fetch_en_o) begin
        ok = 1'b1;
        break;
      end
      status_i = 1'b0;
      step();
    end
  endtask

  // Runs one campaign of n runs using lat_a/res_a as SoC behaviour.
  // ab_run>0 aborts in RUN cycle ab_cyc of run ab_run. poke_start pulses
  // start_i during run 1 to show it is ignored outside IDLE.
  task automatic campaign(input int n, input int ab_run, input int ab_cyc, input bit poke_start);
    int t, r, k, done_t, fetch_runs, first_rst_hi, first_fetch, busy_lo, done_seen;
    int e_pass, e_fail, e_to, e_last, e_done, e_runs, m;
    bit prev_fetch, aborted;
    if (ab_run > 0 && lat_a[ab_run-1] < ab_cyc) lat_a[ab_run-1] = ab_cyc;
    // Expected campaign outcome from the run rules.
    e_pass = 0; e_fail = 0; e_to = 0; e_last = 0; e_done = 1; e_runs = n;
    for (int i = 0; i < n; i++) begin
      if (ab_run == i + 1) begin
        e_runs = ab_run;
        break;
      end
      m = (lat_a[i] <= TO) ? lat_a[i] : TO;
      e_done += RH + BW + m;
      e_last = m;
      if (lat_a[i] <= TO) begin
        if (res_a[i]) e_pass++; else e_fail++;
      end else begin
        e_fail++;
        e_to++;
      end
    end
    // Stimulus and observation.
    start_i = 1'b1;
    abort_i = 1'b0;
    run_count_i = CW'(n);
    step();
    start_i = 1'b0;
    t = 1; r = 0; k = 0; done_t = -1; fetch_runs = 0;
    first_rst_hi = 0; first_fetch = 0; busy_lo = 0;
    prev_fetch = 1'b0; aborted = 1'b0;
    while (t < 1000) begin
      if (done_o) begin
        done_t = t;
        break;
      end
      if (soc_fetch_en_o && !prev_fetch) begin
        r++;
        k = 0;
        fetch_runs++;
        if (first_fetch == 0) first_fetch = t;
      end
      if (soc_fetch_en_o) k++;
      if (soc_rst_no && first_rst_hi == 0) first_rst_hi = t;
      if (!busy_o) busy_lo++;
      prev_fetch = soc_fetch_en_o;
      abort_i = 1'b0;
      start_i = 1'b0;
      if (soc_fetch_en_o && r >= 1 && r <= n) begin
        status_i = (k == lat_a[r-1]);
        result_i = status_i ? res_a[r-1] : 1'($urandom_range(0, 1));
        if (ab_run == r && k == ab_cyc) begin
          abort_i = 1'b1;
          aborted = 1'b1;
        end
        if (poke_start && r == 1 && k == 2) begin
          start_i = 1'b1;
          run_count_i = CW'(7);
        end
      end else begin
        // Stale or random status outside RUN must be ignored.
        status_i = 1'($urandom_range(0, 1));
        result_i = 1'($urandom_range(0, 1));
      end
      step();
      t++;
      abort_i = 1'b0;
      start_i = 1'b0;
      status_i = 1'b0;
      if (aborted) break;
    end
    check("busy_in_campaign", busy_lo, 0);
    check("run_phases", fetch_runs, e_runs);
    if (n > 0) begin
      check("first_rst_release", first_rst_hi, RH + 1);
      check("first_fetch_en", first_fetch, RH + BW + 1);
    end
    if (aborted) begin
      check("abort_busy", busy_o, 0);
      check("abort_rst_low", soc_rst_no, 0);
      check("abort_fetch_low", soc_fetch_en_o, 0);
      done_seen = 0;
      for (int i = 0; i < 3; i++) begin
        if (done_o) done_seen++;
        step();
      end
      check("abort_no_done", done_seen, 0);
    end else begin
      check("done_time", done_t, e_done);
    end
    check("pass_cnt", pass_cnt_o, e_pass);
    check("fail_cnt", fail_cnt_o, e_fail);
    check("timeout_cnt", timeout_cnt_o, e_to);
    check("last_cycles", last_cycles_o, e_last);
    if (!aborted) begin
      step();
      check("done_one_cycle", done_o, 0);
      check("idle_after_done", busy_o, 0);
      check("idle_rst_low", soc_rst_no, 0);
    end
  endtask

  initial begin
    bit ok;
    int n, ab, abc, sel;

    // Reset state.
    rst_i = 1'b1;
    repeat (3) step();
    check("rst_state", dbg_state_o, IDLE);
    check("rst_soc_rst", soc_rst_no, 0);
    check("rst_fetch", soc_fetch_en_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rst_i = 1'b0;
    step();
    check("idle_busy", busy_o, 0);

    // Reset mid-RUN of run 2 after run 1 passed.
    start_i = 1'b1; run_count_i = CW'(2);
    step();
    start_i = 1'b0;
    wait_fetch(ok);
    check("mr_fetch1_seen", ok, 1);
    step();
    status_i = 1'b1; result_i = 1'b1;
    step();
    status_i = 1'b0;
    wait_fetch(ok);
    check("mr_fetch2_seen", ok, 1);
    repeat (3) step();
    check("mr_pass_before", pass_cnt_o, 1);
    rst_i = 1'b1;
    step();
    check("mr_busy", busy_o, 0);
    check("mr_rst_low", soc_rst_no, 0);
    check("mr_fetch_low", soc_fetch_en_o, 0);
    check("mr_pass", pass_cnt_o, 0);
    check("mr_last", last_cycles_o, 0);
    repeat (2) step();
    rst_i = 1'b0;
    step();

    // Abort in IDLE is a no-op; abort together with start blocks the start.
    abort_i = 1'b1;
    step();
    check("idle_abort_busy", busy_o, 0);
    start_i = 1'b1; run_count_i = CW'(2);
    step();
    check("abort_start_busy", busy_o, 0);
    abort_i = 1'b0; start_i = 1'b0;
    step();

    // Single pass at RUN cycle 10.
    lat_a[0] = 10; res_a[0] = 1'b1;
    campaign(1, 0, 0, 1'b0);
    // Single timeout.
    lat_a[0] = TO + 50; res_a[0] = 1'b1;
    campaign(1, 0, 0, 1'b0);
    // Pass, fail, timeout.
    lat_a[0] = 20; res_a[0] = 1'b1;
    lat_a[1] = 30; res_a[1] = 1'b0;
    lat_a[2] = TO + 50; res_a[2] = 1'b1;
    campaign(3, 0, 0, 1'b0);
    // Abort in RUN cycle 3 of run 2, then a zero-run campaign.
    lat_a[0] = 15; res_a[0] = 1'b1;
    lat_a[1] = 50; res_a[1] = 1'b1;
    for (int i = 2; i < 5; i++) begin lat_a[i] = 10; res_a[i] = 1'b1; end
    campaign(5, 2, 3, 1'b0);
    campaign(0, 0, 0, 1'b0);
    // Completion exactly on the timeout cycle, start pulsed in RUN.
    lat_a[0] = TO; res_a[0] = 1'b1;
    campaign(1, 0, 0, 1'b1);
    // Abort on a completion cycle wins.
    lat_a[0] = 7; res_a[0] = 1'b1;
    lat_a[1] = 9; res_a[1] = 1'b1;
    campaign(2, 1, 7, 1'b0);

    // Randomized campaigns.
    for (int c = 0; c < 15; c++) begin
      n = $urandom_range(0, 4);
      for (int i = 0; i < 8; i++) begin
        sel = $urandom_range(0, 9);
        if (sel < 2) lat_a[i] = TO + 50;
        else if (sel == 2) lat_a[i] = TO;
        else lat_a[i] = $urandom_range(1, TO - 1);
        res_a[i] = 1'($urandom_range(0, 1));
      end
      ab = 0;
      abc = 0;
      if (n > 0 && $urandom_range(0, 4) == 0) begin
        ab = $urandom_range(1, n);
        abc = $urandom_range(1, TO);
      end
      campaign(n, ab, abc, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
